// File: rtl/fc_layer_seq.sv
// Phase sequencer for one fully-connected layer: counts ibuf writes, then
// runs control unit -> CIM tiles -> function unit and reports status.
module fc_layer_seq #(
  parameter int input_size   = 4096,
  parameter int busy_timeout = 64,
  parameter int cnt_width    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_ibuf_we,
  input  logic                            i_ctrl_busy,
  input  logic                            i_cim_busy,
  input  logic                            i_func_busy,
  input  logic                            i_next_busy,
  input  logic                            i_clr,
  output logic                            o_ctrl_start,
  output logic                            o_cim_start,
  output logic                            o_func_start,
  output logic                            o_ready,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [2:0]                      o_state,
  output logic [$clog2(input_size+1)-1:0] o_wr_cnt,
  output logic [cnt_width-1:0]            o_pass_cnt,
  output logic                            o_err_overrun,
  output logic                            o_err_timeout
);
  localparam int WCW = $clog2(input_size+1);
  localparam int TW  = $clog2(busy_timeout+1);

  typedef enum logic [2:0] {
    FILL = 3'd0, S_CTRL = 3'd1, W_CTRL = 3'd2, S_CIM = 3'd3,
    W_CIM = 3'd4, W_NEXT = 3'd5, S_FUNC = 3'd6, W_FUNC = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [WCW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [cnt_width-1:0] pass_cnt_q, pass_cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 seen_q, seen_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 terr_q, terr_d;
  logic                 eng_busy, tmo_evt;

  always_comb begin
    case (state_q)
      W_CTRL:  eng_busy = i_ctrl_busy;
      W_CIM:   eng_busy = i_cim_busy;
      W_FUNC:  eng_busy = i_func_busy;
      default: eng_busy = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    pass_cnt_d = pass_cnt_q;
    tmo_d      = tmo_q;
    seen_d     = seen_q;
    done_d     = 1'b0;
    tmo_evt    = 1'b0;
    case (state_q)
      FILL: if (i_ibuf_we) begin
        wr_cnt_d = wr_cnt_q + WCW'(1);
        if (wr_cnt_q == WCW'(input_size - 1)) state_d = S_CTRL;
      end
      S_CTRL, S_CIM, S_FUNC: begin
        tmo_d  = '0;
        seen_d = 1'b0;
        state_d = (state_q == S_CTRL) ? W_CTRL :
                  (state_q == S_CIM)  ? W_CIM  : W_FUNC;
      end
      W_NEXT: if (!i_next_busy) state_d = S_FUNC;
      default: begin
        // Phase A waits (bounded) for busy to rise; phase B waits unbounded for it to fall.
        if (!seen_q) begin
          if (eng_busy) seen_d = 1'b1;
          else if (tmo_q == TW'(busy_timeout - 1)) begin
            tmo_evt  = 1'b1;
            state_d  = FILL;
            wr_cnt_d = '0;
          end else tmo_d = tmo_q + TW'(1);
        end else if (!eng_busy) begin
          seen_d = 1'b0;
          case (state_q)
            W_CTRL:  state_d = S_CIM;
            W_CIM:   state_d = W_NEXT;
            default: begin
              state_d    = FILL;
              done_d     = 1'b1;
              wr_cnt_d   = '0;
              pass_cnt_d = pass_cnt_q + cnt_width'(1);
            end
          endcase
        end
      end
    endcase
    // A new error event in the same cycle as i_clr keeps the flag set.
    ovr_d  = (ovr_q & ~i_clr) | (i_ibuf_we & (state_q != FILL));
    terr_d = (terr_q & ~i_clr) | tmo_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      wr_cnt_q   <= '0;
      pass_cnt_q <= '0;
      tmo_q      <= '0;
      seen_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      tmo_q      <= tmo_d;
      seen_q     <= seen_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      terr_q     <= terr_d;
    end
  end

  assign o_ctrl_start  = (state_q == S_CTRL);
  assign o_cim_start   = (state_q == S_CIM);
  assign o_func_start  = (state_q == S_FUNC);
  assign o_ready       = (state_q == FILL);
  assign o_busy        = (state_q != FILL);
  assign o_done        = done_q;
  assign o_state       = state_q;
  assign o_wr_cnt      = wr_cnt_q;
  assign o_pass_cnt    = pass_cnt_q;
  assign o_err_overrun = ovr_q;
  assign o_err_timeout = terr_q;
endmodule
